// File: rtl/alu_pkg.sv
// Shared opcode map, flag bundle and skid-buffer state encoding for the ALU result stage.
package alu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'd0;
    localparam opcode_t OP_SUB  = 5'd1;
    localparam opcode_t OP_MUL  = 5'd2;
    localparam opcode_t OP_DIV  = 5'd3;
    localparam opcode_t OP_AND  = 5'd4;
    localparam opcode_t OP_OR   = 5'd5;
    localparam opcode_t OP_XOR  = 5'd6;
    localparam opcode_t OP_NOR  = 5'd7;
    localparam opcode_t OP_NAND = 5'd8;
    localparam opcode_t OP_XNOR = 5'd9;
    localparam opcode_t OP_CMP  = 5'd10;
    localparam opcode_t OP_SLL  = 5'd11;
    localparam opcode_t OP_SRL  = 5'd12;
    localparam opcode_t OP_ROL  = 5'd13;
    localparam opcode_t OP_ROR  = 5'd14;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic logic is_illegal_op(input opcode_t op);
        return op > OP_ROR;
    endfunction

    // Only add/sub produce meaningful ALU flags.
    function automatic logic is_flag_op(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake, payload and flag signals between the ALU, the result stage and writeback.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    opcode_t         in_opcode;
    logic [N-1:0]    in_result;
    logic            in_v;
    logic            in_c;
    logic            in_n;
    logic            in_z;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    opcode_t         out_opcode;
    logic [N-1:0]    out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_illegal;
    logic [3:0]      nzcv_q;
    logic            sticky_v;
    logic            clr_sticky;

    modport master (
        output in_valid, in_opcode, in_result, in_v, in_c, in_n, in_z, in_rd,
        output out_ready, clr_sticky,
        input  in_ready, out_valid, out_opcode, out_result, out_rd, out_illegal,
        input  nzcv_q, sticky_v
    );

    modport slave (
        input  in_valid, in_opcode, in_result, in_v, in_c, in_n, in_z, in_rd,
        input  out_ready, clr_sticky,
        output in_ready, out_valid, out_opcode, out_result, out_rd, out_illegal,
        output nzcv_q, sticky_v
    );
endinterface

// File: rtl/alu_result_stage_skid_reg.sv
// Two-entry valid/ready skid buffer: main entry drives the output, skid entry absorbs one beat of backpressure.
module skid_reg
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    state_t       state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         accept, drain;
    logic         load_main_in, load_main_skid, load_skid;

    // in_ready decodes the state flop only, so out_ready never reaches it combinationally.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // NOTE: payload registers are reset too, because the output payload must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback register stage with architectural NZCV commit on add/sub drains.
// Optional sticky overflow flag enabled by defining ALU_RESULT_STICKY_V_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int RD_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_stage_if.slave   bus
);
    localparam int W = 5 + N + RD_W + 4;

    logic [W-1:0] in_data, out_data;
    flags_t       out_flags;
    flags_t       nzcv;
    logic         drain, commit;

    assign in_data = {bus.in_opcode, bus.in_result, bus.in_rd,
                      bus.in_n, bus.in_z, bus.in_c, bus.in_v};

    skid_reg #(.W(W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign {bus.out_opcode, bus.out_result, bus.out_rd, out_flags} = out_data;
    assign bus.out_illegal = is_illegal_op(bus.out_opcode);

    // Flags commit when the entry leaves the stage, so they stay in program order.
    assign drain  = bus.out_valid && bus.out_ready;
    assign commit = drain && is_flag_op(bus.out_opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      nzcv <= '0;
        else if (commit) nzcv <= out_flags;
    end

    assign bus.nzcv_q = nzcv;

`ifdef ALU_RESULT_STICKY_V_EN
    logic sticky_q;

    // A setting commit takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     sticky_q <= 1'b0;
        else if (commit && out_flags.v) sticky_q <= 1'b1;
        else if (bus.clr_sticky)        sticky_q <= 1'b0;
    end

    assign bus.sticky_v = sticky_q;
`else
    logic unused_clr_sticky;

    assign unused_clr_sticky = bus.clr_sticky;
    assign bus.sticky_v      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_stage;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        logic [4:0]  rd;
        logic [3:0]  nzcv;
    } txn_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   beats;
    txn_t exp_q[$];
    txn_t cur;
    logic [3:0]  m_nzcv;
    logic        m_sticky;
    logic        hold_valid;
    logic [41:0] held;

    alu_result_stage_if #(.N(32), .RD_W(5)) bus ();

    alu_result_stage #(.N(32), .RD_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic flag_op(input logic [4:0] op);
        return (op == 5'd0) || (op == 5'd1);
    endfunction

    // Monitor: compares every presented beat with the front of the scoreboard and tracks flag state.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_nzcv     = 4'b0000;
            m_sticky   = 1'b0;
            hold_valid = 1'b0;
        end else begin
            check("nzcv_q", bus.nzcv_q, m_nzcv);
            check("sticky_v", bus.sticky_v, m_sticky);
            if (hold_valid)
                check("hold_stable", {bus.out_opcode, bus.out_result, bus.out_rd}, held);
            if (bus.out_valid && exp_q.size() == 0) begin
                check("spurious_out_valid", bus.out_valid, 1'b0);
            end else if (bus.out_valid) begin
                cur = exp_q[0];
                check("out_result", bus.out_result, cur.res);
                check("out_opcode", bus.out_opcode, cur.op);
                check("out_rd", bus.out_rd, cur.rd);
                check("out_illegal", bus.out_illegal, cur.op >= 5'd15);
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                beats++;
                if (flag_op(cur.op)) m_nzcv = cur.nzcv;
`ifdef ALU_RESULT_STICKY_V_EN
                if (flag_op(cur.op) && cur.nzcv[0]) m_sticky = 1'b1;
                else if (bus.clr_sticky)            m_sticky = 1'b0;
            end else if (bus.clr_sticky) begin
                m_sticky = 1'b0;
`endif
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            held       = {bus.out_opcode, bus.out_result, bus.out_rd};
        end
    end

    // Drives one beat and waits (bounded) for acceptance; returns the number of stalled cycles.
    task automatic send(input logic [4:0] op, input logic [31:0] res, input logic [4:0] rd,
                        input logic [3:0] nzcv, output int waits);
        txn_t t;
        logic accepted;
        t.op = op; t.res = res; t.rd = rd; t.nzcv = nzcv;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_result = res;
        bus.in_rd     = rd;
        {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = nzcv;
        waits    = 0;
        accepted = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(t);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
            waits++;
        end
        check("send_accepted", accepted, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int w;
    int total_waits;
    int b0;

    initial begin
        n_checks = 0; n_fail = 0; beats = 0;
        m_nzcv = 4'b0000; m_sticky = 1'b0; hold_valid = 1'b0; held = '0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_result = '0; bus.in_rd = '0;
        {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = 4'b0000;
        bus.out_ready = 1'b0; bus.clr_sticky = 1'b0;
        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_nzcv", bus.nzcv_q, 4'b0000);
        #11 rst_n = 1'b1;
        cycles(2);

        // Single ADD: one-cycle latency.
        bus.out_ready = 1'b1;
        send(5'd0, 32'h0000_0005, 5'd1, 4'b0000, w);
        check("lat_out_valid", bus.out_valid, 1'b1);
        check("lat_out_result", bus.out_result, 32'h5);
        cycles(2);
        check("add_nzcv", bus.nzcv_q, 4'b0000);

        // Backpressure: SUB then AND fill both entries; a third beat is held off.
        bus.out_ready = 1'b0;
        send(5'd1, 32'hFFFF_FFFF, 5'd3, 4'b1000, w);
        send(5'd4, 32'h0000_000F, 5'd4, 4'b0101, w);
        check("full_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1; bus.in_opcode = 5'd6; bus.in_result = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        send(5'd6, 32'h0000_1234, 5'd5, 4'b0011, w);
        cycles(3);
        check("sub_and_nzcv", bus.nzcv_q, 4'b1000);

        // Eight back-to-back ADDs with no bubbles.
        b0 = beats;
        total_waits = 0;
        for (int i = 0; i < 8; i++) begin
            send(5'd0, 32'(i * 3 + 1), 5'(i), 4'($urandom_range(0, 15)), w);
            total_waits += w;
        end
        @(negedge clk); #1;
        check("b2b_waits", total_waits, 0);
        check("b2b_beats", beats - b0, 8);
        cycles(2);

        // Illegal opcode passes through without committing flags.
        send(5'd20, 32'hDEAD_BEEF, 5'd9, 4'b0001, w);
        check("illegal_flag", bus.out_illegal, 1'b1);
        cycles(2);

        // Sticky overflow: set, set-wins-over-clear, lone clear.
        send(5'd0, 32'h8000_0000, 5'd2, 4'b1001, w);
        cycles(2);
`ifdef ALU_RESULT_STICKY_V_EN
        check("sticky_set", bus.sticky_v, 1'b1);
`else
        check("sticky_off", bus.sticky_v, 1'b0);
`endif
        send(5'd1, 32'h8000_0001, 5'd2, 4'b1001, w);
        bus.clr_sticky = 1'b1;
        cycles(1);
        bus.clr_sticky = 1'b0;
        cycles(1);
`ifdef ALU_RESULT_STICKY_V_EN
        check("sticky_set_wins", bus.sticky_v, 1'b1);
`else
        check("sticky_off", bus.sticky_v, 1'b0);
`endif
        bus.clr_sticky = 1'b1;
        cycles(1);
        bus.clr_sticky = 1'b0;
        cycles(1);
        check("sticky_clear", bus.sticky_v, 1'b0);

        // Asynchronous reset while both entries are full.
        bus.out_ready = 1'b0;
        send(5'd0, 32'h11, 5'd1, 4'b1111, w);
        send(5'd1, 32'h22, 5'd2, 4'b0110, w);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_nzcv", bus.nzcv_q, 4'b0000);
        check("arst_out_result", bus.out_result, 32'h0);
        check("arst_sticky", bus.sticky_v, 1'b0);
        @(negedge clk); @(negedge clk); #2;
        rst_n = 1'b1;
        cycles(2);

        // Randomized traffic with random backpressure and clears.
        fork
            begin
                repeat (600) begin
                    @(posedge clk); #1;
                    bus.out_ready  = ($urandom_range(0, 3) != 0);
                    bus.clr_sticky = ($urandom_range(0, 7) == 0);
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [4:0] op;
                    op = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 31));
                    send(op, $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), w);
                end
            end
        join
        bus.out_ready = 1'b1;
        bus.clr_sticky = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            cycles(1);
        end
        check("drain_all", exp_q.size(), 0);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-to-writeback pipeline register placed directly downstream of the combinational ALU. It captures each ALU result with its opcode, destination tag and flags through a valid/ready handshake, using a 2-entry skid buffer for full throughput with registered `in_ready`. It also owns the architectural NZCV flag register, committing flags only for add/sub results.

## Interface
- `N`, 32: datapath width; must match the ALU `N`.
- `RD_W`, 5: destination-register tag width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU output is valid this cycle.
- `in_ready`  out  1  stage can accept; registered, equals "skid entry empty".
- `in_opcode`  in  5  opcode the ALU executed.
- `in_result`  in  N  ALU `alu_out`.
- `in_v`, `in_c`, `in_n`, `in_z`  in  1 each  ALU flags `V`, `C`, `N_`, `Z_`; `in_z`=1 means result is zero.
- `in_rd`  in  RD_W  destination tag.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  writeback accepts.
- `out_opcode`  out  5, `out_result`  out  N, `out_rd`  out  RD_W: registered payload.
- `out_illegal`  out  1  payload opcode is in 15..31.
- `nzcv_q`  out  4  committed flags {N,Z,C,V}.
- `sticky_v`  out  1  sticky overflow (see Configuration).
- `clr_sticky`  in  1  synchronous clear of `sticky_v`.

## Operation
- Opcode map (package): ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, NOR=7, NAND=8, XNOR=9, CMP=10, SLL=11, SRL=12, ROL=13, ROR=14; 15..31 illegal.
- Entries: main (drives `out_*`) and skid. State EMPTY (none valid), ONE (main), TWO (main+skid).
- Accept = `in_valid && in_ready`; drain = `out_valid && out_ready`.
- EMPTY: accept -> ONE (main loads input).
- ONE: accept & drain -> ONE (main reloads); accept & !drain -> TWO (skid loads); drain only -> EMPTY.
- TWO (`in_ready`=0, no accept): drain -> ONE (main loads skid); else hold.
- Payload stored in skid is the full input bundle incl. flags; order is strictly FIFO.
- Flag commit on drain only: if `out_opcode` is ADD or SUB, `nzcv_q` <= stored {n,z,c,v}; all other opcodes leave `nzcv_q` unchanged (ALU flags are undefined for them).
- `out_illegal` = decode of `out_opcode`; illegal entries still pass through but never commit flags.
- MUL/DIV pass through unchanged (result as supplied).
- `out_*` payload holds stable while `out_valid && !out_ready`.

## Timing
- Latency: input accepted at edge k appears on `out_*` after edge k (1 cycle) when empty.
- Throughput 1 entry/cycle with `out_ready` held high.
- `in_ready` depends only on state (no combinational path from `out_ready`).
- Reset (asynchronous, any time incl. mid-transfer): state EMPTY, `out_valid`=0, `in_ready`=1, `out_*` payload 0, `nzcv_q`=4'b0000, `sticky_v`=0; in-flight entries are discarded.
- `nzcv_q` updates on the edge of the drain handshake; visible the next cycle.
- `clr_sticky` and a setting commit in the same cycle: set wins.

## Configuration
- `ALU_RESULT_STICKY_V_EN` defined: `sticky_v` sets on any committed ADD/SUB with v=1, held until `clr_sticky` or reset.
- Not defined: `sticky_v` tied 0, `clr_sticky` ignored, no extra flop; ports remain present.

## Structure
- Package `alu_pkg`: 5-bit opcode typedef and OP_* constants, `is_illegal_op`/`is_flag_op` functions, flag-bundle struct {n,z,c,v}, state enum {EMPTY, ONE, TWO}.
- One sub-module natural: `skid_reg` (parameterised payload width, 2-entry valid/ready buffer); flag logic stays in the top.

## Test plan
- Reset, then ADD result 0x0000_0005 flags n0 z0 c0 v0 with `out_ready`=1 -> `out_result`=5 one cycle later, `nzcv_q`=0000.
- `out_ready`=0, issue SUB (0xFFFF_FFFF, n1) then AND (0x0F) -> `in_ready` drops after 2nd accept, third `in_valid` held off; release -> SUB then AND in order, `nzcv_q`=1000 after SUB, unchanged after AND.
- Back-to-back 8 ADDs with `out_ready`=1 -> 8 consecutive output beats, no bubbles.
- Opcode 20 with v=1 -> `out_illegal`=1, `nzcv_q` and `sticky_v` unchanged.
- With macro: ADD v=1 commit -> `sticky_v`=1; same-cycle `clr_sticky`+v=1 SUB -> stays 1; lone `clr_sticky` -> 0.
- Assert `rst_n`=0 while in TWO -> `out_valid`=0, `in_ready`=1, `nzcv_q`=0 immediately.
